// File: rtl/wishbone_arbiter_pkg.sv
// Shared Wishbone widths and arbiter state encodings.
package wishbone_arbiter_pkg;
    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 64;
    localparam int TMO_W     = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_ERR     = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;
endpackage

// File: rtl/wishbone_arbiter_if.sv
// Requester-side and shared-bus signals of the Wishbone arbiter.
interface wishbone_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import wishbone_arbiter_pkg::*;

    // Packed per-requester arrays: requester k sits at bits [W*k+W-1:W*k].
    logic [NUM_REQ-1:0]                s_cyc_i;
    logic [NUM_REQ-1:0]                s_stb_i;
    logic [NUM_REQ-1:0]                s_we_i;
    logic [NUM_REQ-1:0][WB_ADDR_W-1:0] s_addr_i;
    logic [NUM_REQ-1:0][WB_DATA_W-1:0] s_data_i;
    logic [WB_DATA_W-1:0]              s_data_o;
    logic [NUM_REQ-1:0]                s_ack_o;
    logic [NUM_REQ-1:0]                s_err_o;

    logic                              m_cyc_o;
    logic                              m_stb_o;
    logic                              m_we_o;
    logic [WB_ADDR_W-1:0]              m_addr_o;
    logic [WB_DATA_W-1:0]              m_data_o;
    logic [WB_DATA_W-1:0]              m_data_i;
    logic                              m_ack_i;

    // Arbiter side.
    modport slave (
        input  s_cyc_i, s_stb_i, s_we_i, s_addr_i, s_data_i, m_data_i, m_ack_i,
        output s_data_o, s_ack_o, s_err_o, m_cyc_o, m_stb_o, m_we_o, m_addr_o, m_data_o
    );

    // Environment side: requesters plus the shared slave.
    modport master (
        output s_cyc_i, s_stb_i, s_we_i, s_addr_i, s_data_i, m_data_i, m_ack_i,
        input  s_data_o, s_ack_o, s_err_o, m_cyc_o, m_stb_o, m_we_o, m_addr_o, m_data_o
    );
endinterface

// File: rtl/wishbone_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_i, wrapping.
module wishbone_arbiter_rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);
    // Scan from the farthest offset down so the nearest requester overwrites.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = N; i >= 1; i--) begin
            if (req_i[(int'(last_i) + i) % N]) begin
                gnt_o = '0;
                gnt_o[(int'(last_i) + i) % N] = 1'b1;
                idx_o = IDX_W'((int'(last_i) + i) % N);
                vld_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter sharing one classic Wishbone bus among NUM_REQ masters,
// with a watchdog that ends an unacknowledged cycle with ERR.
module wishbone_arbiter
    import wishbone_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    wishbone_arbiter_if.slave   bus,
    output logic [NUM_REQ-1:0]  grant_o,
    output logic                busy_o
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d, tmo_inc;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic               in_grant;
    logic               own_cyc;

    wishbone_arbiter_rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .req_i  (bus.s_cyc_i),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .vld_o  (pick_vld)
    );

    // last_q doubles as the owner index for as long as a grant is held.
    assign in_grant = (state_q == ST_GRANT);
    assign own_cyc  = bus.s_cyc_i[last_q];

    assign bus.m_cyc_o  = in_grant & own_cyc;
    assign bus.m_stb_o  = in_grant & bus.s_stb_i[last_q];
    assign bus.m_we_o   = in_grant & bus.s_we_i[last_q];
    assign bus.m_addr_o = in_grant ? bus.s_addr_i[last_q] : '0;
    assign bus.m_data_o = in_grant ? bus.s_data_i[last_q] : '0;

    assign bus.s_data_o = bus.m_data_i;
    assign bus.s_ack_o  = (in_grant && bus.m_ack_i) ? grant_q : '0;
    assign bus.s_err_o  = (state_q == ST_ERR) ? grant_q : '0;

    assign grant_o = grant_q;
    assign busy_o  = (state_q != ST_IDLE);

    assign tmo_inc = (&tmo_q) ? tmo_q : tmo_q + 1'b1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        tmo_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_GRANT;
                    grant_d = pick_gnt;
                    last_d  = pick_idx;
                end
            end
            ST_GRANT: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (!bus.m_ack_i && bus.m_stb_o) begin
                    // ACK on the limit cycle takes the other branch and clears.
                    if (tmo_inc >= TMO_W'(TIMEOUT_CYCLES)) begin
                        state_d = ST_ERR;
                    end else begin
                        tmo_d = tmo_inc;
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_RELEASE;
            end
            default: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
        end
    end
endmodule

// File: tb/tb_wishbone_arbiter.sv
// Randomized bench for wishbone_arbiter, checked every cycle against an owner-based reference model.
module tb_wishbone_arbiter;
    import wishbone_arbiter_pkg::*;

    localparam int N   = 3;
    localparam int TMO = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] grant;
    logic         busy;

    always #5 clk = ~clk;

    wishbone_arbiter_if #(.NUM_REQ(N)) bus ();

    wishbone_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .bus     (bus),
        .grant_o (grant),
        .busy_o  (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: who owns the bus, whether the owner's cycle was aborted,
    // and how long the owner's strobe has gone unanswered.
    int owner   = -1;
    int last    = N - 1;
    int stall   = 0;
    bit err_now = 1'b0;
    bit aborted = 1'b0;
    logic [N-1:0] term;

    task automatic model_edge();
        if (!rst_n) begin
            owner = -1; last = N - 1; stall = 0; err_now = 0; aborted = 0;
        end else if (owner < 0) begin
            for (int i = 1; i <= N; i++) begin
                if (bus.s_cyc_i[(last + i) % N]) begin
                    owner = (last + i) % N;
                    break;
                end
            end
            if (owner >= 0) last = owner;
            stall = 0;
        end else if (err_now) begin
            err_now = 0; aborted = 1;
        end else if (aborted) begin
            if (!bus.s_cyc_i[owner]) begin owner = -1; aborted = 0; end
        end else if (!bus.s_cyc_i[owner]) begin
            owner = -1; stall = 0;
        end else if (bus.m_ack_i || !bus.s_stb_i[owner]) begin
            stall = 0;
        end else begin
            if (stall < 65535) stall++;
            if (stall >= TMO) begin err_now = 1; stall = 0; end
        end
    endtask

    task automatic check_now();
        bit           act;
        logic [N-1:0] one;
        #1;
        act = (owner >= 0) && !err_now && !aborted;
        one = (owner >= 0) ? N'(1 << owner) : '0;
        chk("grant",  grant, one);
        chk("busy",   busy, owner >= 0);
        chk("m_cyc",  bus.m_cyc_o, act ? bus.s_cyc_i[owner] : 1'b0);
        chk("m_stb",  bus.m_stb_o, act ? bus.s_stb_i[owner] : 1'b0);
        chk("m_we",   bus.m_we_o,  act ? bus.s_we_i[owner]  : 1'b0);
        chk("m_addr", bus.m_addr_o, act ? bus.s_addr_i[owner] : 32'h0);
        chk("m_data", bus.m_data_o, act ? bus.s_data_i[owner] : 64'h0);
        chk("s_ack",  bus.s_ack_o, (act && bus.m_ack_i) ? one : '0);
        chk("s_err",  bus.s_err_o, err_now ? one : '0);
        chk("s_data", bus.s_data_o, bus.m_data_i);
        term = bus.s_ack_o | bus.s_err_o;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cyc_step();
        check_now();
        tick();
    endtask

    task automatic new_xfer(input int k);
        bus.s_we_i[k]   = 1'($urandom);
        bus.s_addr_i[k] = $urandom;
        bus.s_data_i[k] = {$urandom, $urandom};
    endtask

    int t_stb, t_err, acks, errs, g;
    bit dead;

    initial begin
        rst_n = 1'b0;
        bus.s_cyc_i = '0; bus.s_stb_i = '0; bus.s_we_i = '0;
        bus.s_addr_i = '0; bus.s_data_i = '0;
        bus.m_ack_i = 1'b0; bus.m_data_i = '0;
        term = '0;
        tick();
        tick();
        cyc_step();                       // reset state
        rst_n = 1'b1;

        // Timeout: req0 reads 0x10 from a slave that never answers.
        bus.s_cyc_i[0] = 1'b1; bus.s_stb_i[0] = 1'b1; bus.s_addr_i[0] = 32'h10;
        t_stb = -1; t_err = -1;
        for (int n = 0; n < 20 && t_err < 0; n++) begin
            check_now();
            if (bus.m_stb_o && t_stb < 0) t_stb = n;
            if (bus.s_err_o[0]) t_err = n;
            tick();
        end
        chk("tmo_latency", 64'(t_err - t_stb), 64'(TMO));
        for (int n = 0; n < 3; n++) cyc_step();   // RELEASE holds while CYC stays high
        bus.s_cyc_i[0] = 1'b0; bus.s_stb_i[0] = 1'b0;
        cyc_step();
        cyc_step();

        // ACK on the cycle the counter would reach the limit.
        bus.s_cyc_i[1] = 1'b1; bus.s_stb_i[1] = 1'b1; new_xfer(1);
        bus.m_data_i = 64'h1122334455667788;
        g = 0; acks = 0; errs = 0;
        for (int n = 0; n < 8; n++) begin
            bus.m_ack_i = (g == TMO - 1);
            check_now();
            if (bus.m_stb_o) g++;
            if (bus.s_ack_o[1]) acks++;
            if (|bus.s_err_o) errs++;
            tick();
        end
        bus.m_ack_i = 1'b0;
        chk("ack_on_limit_acks", 64'(acks), 64'd1);
        chk("ack_on_limit_errs", 64'(errs), 64'd0);

        // Reset mid-GRANT, then both requesters compete: req0 must win.
        rst_n = 1'b0;
        cyc_step();
        rst_n = 1'b1;
        bus.s_cyc_i[0] = 1'b1; bus.s_stb_i[0] = 1'b1; new_xfer(0);
        cyc_step();
        check_now();
        chk("prio_after_rst", 64'(grant), 64'd1);
        tick();

        // Randomized traffic with a flaky slave and occasional resets.
        dead = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (bus.s_cyc_i[k]) begin
                    if ((term[k] && $urandom_range(1, 0) == 1) || $urandom_range(31, 0) == 0) begin
                        bus.s_cyc_i[k] = 1'b0;
                        bus.s_stb_i[k] = 1'b0;
                    end else begin
                        if (term[k]) new_xfer(k);
                        bus.s_stb_i[k] = ($urandom_range(7, 0) != 0);
                    end
                end else if ($urandom_range(2, 0) == 0) begin
                    bus.s_cyc_i[k] = 1'b1;
                    bus.s_stb_i[k] = 1'b1;
                    new_xfer(k);
                end
            end
            if ($urandom_range(39, 0) == 0) dead = !dead;
            bus.m_ack_i  = !dead && ($urandom_range(2, 0) == 0);
            bus.m_data_i = {$urandom, $urandom};
            rst_n = ($urandom_range(299, 0) != 0);
            cyc_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
